eth_ptp_ts_capture: RTL
=======================

// Module: eth_ptp_ts_capture
// PURPOSE
//  AXI-stream pass-through stage for the MAC TX path. Captures PTP time at the first beat of each frame and queues {ts, tag} for software/host readback.
//  Parametrised successor to the single-timestamp MAC model interface: configurable widths, multi-entry timestamp FIFO, bad-frame filtering and overflow reporting.
// PARAMETERS
//  DATA_WIDTH     64               AXIS data width, bits
//  KEEP_WIDTH     DATA_WIDTH/8     AXIS tkeep width
//  PTP_TS_WIDTH   96               PTP timestamp width
//  PTP_TAG_WIDTH  16               timestamp tag width
//  USER_WIDTH     PTP_TAG_WIDTH+1  tuser width: [0]=bad frame, [USER_WIDTH-1:1]=tag
//  TS_FIFO_DEPTH  4                timestamp FIFO entries, power of two >= 2
//  DROP_BAD_TS    1                1: no timestamp queued for frames with tuser[0]=1 on last beat
// PORTS
//  clk             in   1                         clock
//  rst             in   1                         asynchronous active-high reset
//  s_axis_tdata    in   DATA_WIDTH                input frame data
//  s_axis_tkeep    in   KEEP_WIDTH                input byte enables
//  s_axis_tlast    in   1                         input end of frame
//  s_axis_tuser    in   USER_WIDTH                input {tag, bad}
//  s_axis_tvalid   in   1                         input valid
//  s_axis_tready   out  1                         input ready
//  m_axis_tdata    out  DATA_WIDTH                output frame data
//  m_axis_tkeep    out  KEEP_WIDTH                output byte enables
//  m_axis_tlast    out  1                         output end of frame
//  m_axis_tuser    out  USER_WIDTH                output {tag, bad}, unmodified
//  m_axis_tvalid   out  1                         output valid
//  m_axis_tready   in   1                         output ready
//  ptp_time        in   PTP_TS_WIDTH              current PTP time, same clock domain
//  m_ts            out  PTP_TS_WIDTH              queued timestamp
//  m_ts_tag        out  PTP_TAG_WIDTH             tag of queued timestamp
//  m_ts_valid      out  1                         timestamp FIFO not empty
//  m_ts_ready      in   1                         pop timestamp
//  ts_overflow     out  1                         one-cycle pulse: timestamp dropped, FIFO full
//  ts_count        out  $clog2(TS_FIFO_DEPTH)+1   FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync release): m_axis_tvalid=0, m_ts_valid=0, ts_overflow=0, ts_count=0. Data/ts/tag outputs are 0. FIFO is emptied; SOF flag=1.
//  Data path: one register stage, latency 1 cycle. s_axis_tready = m_axis_tready | ~m_axis_tvalid (comb).
//   On an accepted input beat, all s_axis fields load into the m_axis register, which sets m_axis_tvalid.
//   m_axis_tvalid clears when an output beat is accepted and no input beat is accepted in the same cycle.
//   Full throughput with no bubbles while m_axis_tready=1. Output fields are stable while m_axis_tvalid & ~m_axis_tready.
//  SOF flag: set by reset and by an accepted beat with tlast=1; cleared by an accepted beat with tlast=0.
//  Capture: an accepted beat with SOF=1 latches pend_ts=ptp_time (value in that cycle) and pend_tag=s_axis_tuser[USER_WIDTH-1:1].
//  Commit: on an accepted beat with tlast=1, push {pend_ts, pend_tag}.
//   For a single-beat frame, capture and commit happen in the same cycle and use the current ptp_time and tag.
//   If DROP_BAD_TS=1 and s_axis_tuser[0]=1 on the last beat, no push occurs and there is no overflow.
//   If the FIFO is full and there is no same-cycle pop, the push is dropped and ts_overflow=1 for 1 cycle. FIFO contents are unchanged.
//   A push and a pop in the same cycle with the FIFO full both succeed; count is unchanged.
//  A timestamp enters the FIFO at input-side commit, so m_ts_valid can rise in the same cycle the last beat appears on m_axis.
//  Timestamp FIFO: FIFO order. m_ts/m_ts_tag show the head entry, registered (visible the cycle after push).
//   Pop on m_ts_valid & m_ts_ready. Pointers wrap modulo TS_FIFO_DEPTH; ts_count distinguishes full from empty.
//  Reset mid-frame: pending timestamp discarded, FIFO cleared. The next accepted beat is treated as SOF.
//  No combinational path from m_ts_ready to any output other than through FIFO state.
// TESTING
//  1 single-beat frame, tuser={16'h0005,0}, ptp_time=96'h1000 at accept -> m_axis beat next cycle; m_ts=96'h1000, m_ts_tag=5, ts_count=1.
//  2 3-beat frame, ptp_time incrementing by 1 per cycle from 96'h2000, tag 9 -> m_ts=96'h2000, tag 9; all 3 beats pass unmodified.
//  3 m_axis_tready=0 for 5 cycles mid-frame -> s_axis_tready=0 after 1 held beat; no data lost or duplicated; held output stays stable.
//  4 DEPTH=4, m_ts_ready=0, 5 frames tags 1..5 -> ts_count=4, ts_overflow pulses on frame 5 only; drain yields tags 1,2,3,4.
//  5 DROP_BAD_TS=1, frame with tuser[0]=1 on last beat -> frame passes with tuser intact, ts_count unchanged; DROP_BAD_TS=0 -> timestamp queued.
//  6 rst asserted after beat 1 of 3 -> outputs and count=0 immediately; next frame tag 7 -> one timestamp, tag 7, SOF-time value.

Source files
------------

// File: rtl/eth_ptp_ts_capture.sv
// eth_ptp_ts_capture
//   AXI-stream pass-through register stage for the MAC TX path. PTP time is
//   sampled on the first accepted beat of each frame. When the frame's last
//   beat is accepted, {timestamp, tag} is committed into a small FIFO for host
//   readback.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   s_axis_*        input stream; tuser = {tag, bad}
//   m_axis_*        output stream, one register stage, fields unmodified
//   ptp_time        current PTP time (same clock domain)
//   m_ts/m_ts_tag   FIFO head; m_ts_valid = not empty; m_ts_ready pops
//   ts_overflow     one-cycle pulse when a commit is dropped on a full FIFO
//   ts_count        FIFO occupancy
module eth_ptp_ts_capture #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int PTP_TS_WIDTH  = 96,
  parameter int PTP_TAG_WIDTH = 16,
  parameter int USER_WIDTH    = PTP_TAG_WIDTH+1,
  parameter int TS_FIFO_DEPTH = 4,
  parameter int DROP_BAD_TS   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tlast,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  input  logic [PTP_TS_WIDTH-1:0]          ptp_time,
  output logic [PTP_TS_WIDTH-1:0]          m_ts,
  output logic [PTP_TAG_WIDTH-1:0]         m_ts_tag,
  output logic                             m_ts_valid,
  input  logic                             m_ts_ready,
  output logic                             ts_overflow,
  output logic [$clog2(TS_FIFO_DEPTH):0]   ts_count
);
  localparam int AW = $clog2(TS_FIFO_DEPTH);
  localparam int CW = AW + 1;

  // data stage
  logic                     r_m_valid;
  logic [DATA_WIDTH-1:0]    r_m_data;
  logic [KEEP_WIDTH-1:0]    r_m_keep;
  logic                     r_m_last;
  logic [USER_WIDTH-1:0]    r_m_user;
  logic                     w_in_fire;
  logic                     w_out_fire;

  // frame tracking / capture
  logic                     r_sof;
  logic [PTP_TS_WIDTH-1:0]  r_pend_ts;
  logic [PTP_TAG_WIDTH-1:0] r_pend_tag;
  logic [PTP_TS_WIDTH-1:0]  w_commit_ts;
  logic [PTP_TAG_WIDTH-1:0] w_commit_tag;

  // timestamp FIFO
  logic [PTP_TS_WIDTH-1:0]  r_ts_mem  [TS_FIFO_DEPTH];
  logic [PTP_TAG_WIDTH-1:0] r_tag_mem [TS_FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     r_ovf;
  logic                     w_push_req;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;

  assign s_axis_tready = m_axis_tready | ~r_m_valid;
  assign w_in_fire     = s_axis_tvalid & s_axis_tready;
  assign w_out_fire    = r_m_valid & m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_user  <= '0;
    end else begin
      if (w_in_fire) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_axis_tdata;
        r_m_keep  <= s_axis_tkeep;
        r_m_last  <= s_axis_tlast;
        r_m_user  <= s_axis_tuser;
      end else if (w_out_fire) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tkeep  = r_m_keep;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tuser  = r_m_user;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sof      <= 1'b1;
      r_pend_ts  <= '0;
      r_pend_tag <= '0;
    end else if (w_in_fire) begin
      r_sof <= s_axis_tlast;
      if (r_sof) begin
        r_pend_ts  <= ptp_time;
        r_pend_tag <= s_axis_tuser[USER_WIDTH-1:1];
      end
    end
  end

  // Single-beat frames commit in the capture cycle, so bypass the pending regs.
  assign w_commit_ts  = r_sof ? ptp_time : r_pend_ts;
  assign w_commit_tag = r_sof ? s_axis_tuser[USER_WIDTH-1:1] : r_pend_tag;

  assign w_push_req = w_in_fire & s_axis_tlast &
                      ~((DROP_BAD_TS != 0) & s_axis_tuser[0]);
  assign w_full     = (r_count == CW'(TS_FIFO_DEPTH));
  assign w_pop      = (r_count != '0) & m_ts_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TS_FIFO_DEPTH; i++) begin
        r_ts_mem[i]  <= '0;
        r_tag_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= w_push_req & w_full & ~w_pop;
      if (w_push) begin
        r_ts_mem[r_wr_ptr]  <= w_commit_ts;
        r_tag_mem[r_wr_ptr] <= w_commit_tag;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop & ~w_push) r_count <= r_count - CW'(1);
    end
  end

  assign m_ts        = r_ts_mem[r_rd_ptr];
  assign m_ts_tag    = r_tag_mem[r_rd_ptr];
  assign m_ts_valid  = (r_count != '0);
  assign ts_overflow = r_ovf;
  assign ts_count    = r_count;

endmodule
